// File: rtl/i2s_rx_multi.sv
// I2S / TDM serial-audio receiver: generates bck, lrck and scki from clk, deserialises
// MSB-first slots and hands each one to the consumer through a one-entry holding register.
module i2s_rx_multi #(
  parameter int SAMPLE_W  = 24,
  parameter int SLOT_W    = 32,
  parameter int CHANNELS  = 2,
  parameter int MODE      = 0,
  parameter int BCK_HALF  = 2,
  parameter int SCKI_HALF = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic                         din,
  input  logic                         ready,
  input  logic                         ovr_clr,
  output logic                         bck,
  output logic                         lrck,
  output logic                         scki,
  output logic signed [SAMPLE_W-1:0]   sample,
  output logic [$clog2(CHANNELS)-1:0]  chan,
  output logic                         valid,
  output logic                         frame_start,
  output logic                         overrun
);

  localparam int BIT_W   = $clog2(SLOT_W);
  localparam int CH_W    = $clog2(CHANNELS);
  localparam int BCK_CW  = $clog2(BCK_HALF);
  localparam int SCKI_CW = $clog2(SCKI_HALF + 1);

  localparam logic [BIT_W-1:0]   BIT_LAST  = BIT_W'(SLOT_W - 1);
  localparam logic [BIT_W-1:0]   BIT_MSB   = BIT_W'(1);
  localparam logic [BIT_W-1:0]   BIT_LSB   = BIT_W'(SAMPLE_W);
  localparam logic [CH_W-1:0]    CH_LAST   = CH_W'(CHANNELS - 1);
  localparam logic [CH_W-1:0]    CH_HALF   = CH_W'(CHANNELS / 2);
  localparam logic [BCK_CW-1:0]  BCK_LAST  = BCK_CW'(BCK_HALF - 1);
  localparam logic [SCKI_CW-1:0] SCKI_LAST = SCKI_CW'(SCKI_HALF - 1);

  typedef enum logic [1:0] {IDLE, SYNC, CAPTURE} state_t;

  state_t                     state;
  logic [SCKI_CW-1:0]         scki_cnt;
  logic [BCK_CW-1:0]          bck_cnt;
  logic                       bck_tick, bck_rise, bck_fall;
  logic [BIT_W-1:0]           bit_pos, bit_nxt;
  logic [CH_W-1:0]            slot_idx, slot_nxt;
  logic                       frame_wrap;
  logic                       cap_shift, cap_lsb;
  logic signed [SAMPLE_W-1:0] shreg_p0;
  logic [CH_W-1:0]            chan_p0;
  logic                       vld_p0;
  logic                       drop_p1;

  // ---- serial clock generation (free-running out of reset) ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scki_cnt <= '0;
      scki     <= 1'b0;
    end else if (scki_cnt == SCKI_LAST) begin
      scki_cnt <= '0;
      scki     <= ~scki;
    end else begin
      scki_cnt <= scki_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bck_cnt <= '0;
      bck     <= 1'b0;
    end else if (bck_tick) begin
      bck_cnt <= '0;
      bck     <= ~bck;
    end else begin
      bck_cnt <= bck_cnt + 1'b1;
    end
  end

  // bck_rise/bck_fall mark the clk edge on which the registered bck changes.
  assign bck_tick = (bck_cnt == BCK_LAST);
  assign bck_rise = bck_tick & ~bck;
  assign bck_fall = bck_tick & bck;

  always_comb begin
    bit_nxt  = bit_pos + 1'b1;
    slot_nxt = slot_idx;
    if (bit_pos == BIT_LAST) begin
      bit_nxt  = '0;
      slot_nxt = (slot_idx == CH_LAST) ? '0 : slot_idx + 1'b1;
    end
  end

  assign frame_wrap = bck_fall && (bit_pos == BIT_LAST) && (slot_idx == CH_LAST);

  // ---- slot timing and frame clock ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bit_pos  <= '0;
      slot_idx <= '0;
      lrck     <= 1'b0;
    end else if (bck_fall) begin
      bit_pos  <= bit_nxt;
      slot_idx <= slot_nxt;
      if (MODE == 1)
        lrck <= (slot_nxt == '0) && (bit_nxt == '0);
      else
        lrck <= (slot_nxt >= CH_HALF);
    end
  end

  // ---- capture state machine ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          if (en) state <= SYNC;
        end
        SYNC: begin
          if (!en) begin
            state <= IDLE;
          end else if (frame_wrap) begin
            state       <= CAPTURE;
            frame_start <= 1'b1;
          end
        end
        CAPTURE: begin
          // A dropped enable only takes effect once the running frame is complete.
          if (frame_wrap) begin
            if (en) frame_start <= 1'b1;
            else    state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // One-bck data delay: the MSB sits at bit position 1 of each slot.
  assign cap_shift = bck_rise && (state == CAPTURE) &&
                     (bit_pos >= BIT_MSB) && (bit_pos <= BIT_LSB);
  assign cap_lsb   = cap_shift && (bit_pos == BIT_LSB);

  // ---- p0: deserialiser ----
  always_ff @(posedge clk) begin
    if (cap_shift) shreg_p0 <= {shreg_p0[SAMPLE_W-2:0], din};
    if (cap_lsb)   chan_p0  <= slot_idx;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) vld_p0 <= 1'b0;
    else        vld_p0 <= cap_lsb;
  end

  // A completed slot is lost only if the consumer is still holding the previous one.
  assign drop_p1 = vld_p0 && valid && !ready;

  // ---- p1: holding register and overrun flag ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample  <= '0;
      chan    <= '0;
      valid   <= 1'b0;
      overrun <= 1'b0;
    end else begin
      if (vld_p0 && !drop_p1) begin
        sample <= shreg_p0;
        chan   <= chan_p0;
        valid  <= 1'b1;
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
      if (drop_p1)      overrun <= 1'b1;
      else if (ovr_clr) overrun <= 1'b0;
    end
  end

endmodule

// File: doc/i2s_rx_multi.md
I2S_RX_MULTI -- requirements
Module: i2s_rx_multi

Interface
REQ-001 SHALL have parameter SAMPLE_W, default 24, meaning captured sample width; legal range 8..SLOT_W-1.
REQ-002 SHALL have parameter SLOT_W, default 32, meaning bck cycles per channel slot.
REQ-003 SHALL have parameter CHANNELS, default 2, meaning slots per frame; legal values 2, 4, 8.
REQ-004 SHALL have parameter MODE, default 0, meaning 0 = I2S (lrck 50% duty) and 1 = TDM (one-bck frame-sync pulse).
REQ-005 SHALL have parameter BCK_HALF, default 2, meaning clk cycles per bck half-period; minimum 2.
REQ-006 SHALL have parameter SCKI_HALF, default 1, meaning clk cycles per scki half-period.
REQ-007 SHALL provide port clk, input, 1 bit: the single system clock; all logic is on its rising edge.
REQ-008 SHALL provide port reset, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL provide ports en (in, 1, capture enable), din (in, 1, serial data), ready (in, 1, consumer accept), ovr_clr (in, 1, overrun clear pulse).
REQ-010 SHALL provide ports bck, lrck and scki (out, 1 each), the generated serial clocks.
REQ-011 SHALL provide ports sample (out, SAMPLE_W, signed, MSB-first data), chan (out, log2(CHANNELS), slot index), valid (out, 1), frame_start (out, 1, one-clk pulse) and overrun (out, 1, sticky).

Function
REQ-012 SHALL toggle scki every SCKI_HALF clk cycles and bck every BCK_HALF clk cycles; both run free whenever reset is high, independent of en.
REQ-013 SHALL advance the bit position (0..SLOT_W-1) and slot index (0..CHANNELS-1) on each bck falling edge, wrapping slot CHANNELS-1 to slot 0 (frame boundary).
REQ-014 SHALL, in MODE 0, drive lrck low for slots 0..CHANNELS/2-1 and high for the rest, changing only on bck falling edges.
REQ-015 SHALL, in MODE 1, drive lrck high for exactly the first bck period of slot 0 and low otherwise.
REQ-016 SHALL sample din on the clk edge on which bck goes high, and take the slot MSB at bit position 1 (one-bck delay) and the next SAMPLE_W-1 positions; remaining slot bits are ignored.
REQ-017 SHALL implement state machine IDLE -> SYNC -> CAPTURE: IDLE while en is low; SYNC on en high, waiting for the next frame boundary; CAPTURE from slot 0 of that frame.
REQ-018 SHALL, when en falls during CAPTURE, finish the current frame and enter IDLE at the frame boundary; en rising again in SYNC or CAPTURE has no extra effect.
REQ-019 SHALL pulse frame_start for one clk at each frame boundary at which CAPTURE begins or continues.
REQ-020 SHALL present each completed slot in a one-entry holding register with chan, asserting valid one clk after the LSB capture edge.
REQ-021 SHALL hold sample, chan and valid stable until a clk edge with valid & ready, after which valid deasserts unless a new slot completes on that same edge (new data wins and valid stays high).
REQ-022 SHALL, when a slot completes while valid is high and ready is low, drop the new slot, keep the held data, and set overrun.
REQ-023 SHALL clear overrun on ovr_clr; if ovr_clr and a new overrun coincide, overrun remains set.

Reset
REQ-024 SHALL, while reset is low, force bck, lrck, scki, valid, frame_start and overrun to 0, sample and chan to 0, counters to bit 0 of slot 0, and the state to IDLE.
REQ-025 SHALL, on reset deassertion mid-frame, restart timing from slot 0 bit 0, with no partial sample ever emitted.

Verification
REQ-026 SHALL cover reset: hold reset low 4 clk -> all outputs 0; after release, the first bck rising edge is at clk 2 and lrck = 0.
REQ-027 SHALL cover I2S stereo (defaults), en=1, ready=1, left slot 0x123456 and right slot 0xABCDEF -> sample 0x123456/chan 0, then 0xABCDEF/chan 1, each valid for 1 clk, 128 clk apart.
REQ-028 SHALL cover backpressure: ready=0 across two slots -> held 0x123456/chan 0, second slot dropped, overrun=1 until ovr_clr.
REQ-029 SHALL cover TDM (MODE=1, CHANNELS=4) with slots 0x000001..0x000004 -> lrck high 4 clk per 512-clk frame, chan 0..3 in order with matching data.
REQ-030 SHALL cover enable: en rising at slot 1 -> first valid is slot 0 of the next frame; en falling at slot 0 -> slot 1 is still emitted, then nothing.
REQ-031 SHALL cover reset mid-frame at bit 10 of slot 1 -> no valid output; the next valid is slot 0 of a fresh frame after re-sync.
